exception_source_arbiter: RTL and testbench

//  Upstream interrupt/exception front end for single_cycle_cpu. Synchronises raw expsrc lines,

---
 rtl/exception_source_arbiter.sv | 86 ++++++++
 tb/tb_exception_source_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_source_arbiter.sv
// Exception/interrupt front end: synchronises raw sources, latches rising edges as sticky
// pending requests, masks them and grants by fixed priority with nested in-service tracking.
module exception_source_arbiter #(
  parameter int unsigned NSRC       = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0020,
  parameter int unsigned CNT_W      = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  src_in,
  input  logic             mask_we,
  input  logic [NSRC-1:0]  mask_wdata,
  input  logic             int_ack,
  input  logic             eret,
  output logic             int_req,
  output logic [1:0]       int_id,
  output logic [31:0]      int_vec,
  output logic [NSRC-1:0]  pending,
  output logic [NSRC-1:0]  in_service,
  output logic [CNT_W-1:0] cnt_exc
);

  logic [NSRC-1:0]  sync1_q, sync2_q, edge_q;
  logic [NSRC-1:0]  pending_q, in_service_q, mask_q;
  logic [CNT_W-1:0] cnt_q;

  logic [NSRC-1:0]  rise, eligible, ack_bit, eret_bit;
  logic             ack_ok, svc_found;
  int unsigned      cur;

  assign rise     = sync2_q & ~edge_q;
  assign eligible = pending_q & mask_q;

  always_comb begin
    cur       = NSRC;
    svc_found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (in_service_q[i] && !svc_found) begin
        cur       = i;
        svc_found = 1'b1;
      end
    end
    // Only sources strictly above the innermost active handler may request.
    int_req = 1'b0;
    int_id  = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (eligible[i] && (i < cur) && !int_req) begin
        int_req = 1'b1;
        int_id  = 2'(i);
      end
    end
  end

  assign int_vec  = VEC_BASE + (32'(int_id) * VEC_STRIDE);
  assign ack_ok   = int_ack && int_req;
  assign ack_bit  = ack_ok ? (NSRC'(1) << int_id) : '0;
  assign eret_bit = eret ? (in_service_q & (~in_service_q + NSRC'(1))) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      edge_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '1;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= src_in;
      sync2_q      <= sync1_q;
      edge_q       <= sync2_q;
      pending_q    <= (pending_q & ~ack_bit) | rise;
      in_service_q <= (in_service_q & ~eret_bit) | ack_bit;
      if (mask_we)
        mask_q <= mask_wdata;
      if (ack_ok && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign cnt_exc    = cnt_q;

endmodule

// File: tb/tb_exception_source_arbiter.sv
// Directed scenario bench for exception_source_arbiter; inputs change 1 time unit after the
// rising edge and outputs are checked there, away from the edge.
module tb_exception_source_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  src_in;
  logic        mask_we;
  logic [2:0]  mask_wdata;
  logic        int_ack;
  logic        eret;
  logic        int_req;
  logic [1:0]  int_id;
  logic [31:0] int_vec;
  logic [2:0]  pending;
  logic [2:0]  in_service;
  logic [10:0] cnt_exc;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  exception_source_arbiter #(
    .NSRC(3), .VEC_BASE(32'h0000_0800), .VEC_STRIDE(32'h0000_0020), .CNT_W(11)
  ) dut (
    .clk(clk), .reset(reset), .src_in(src_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .int_ack(int_ack), .eret(eret), .int_req(int_req), .int_id(int_id), .int_vec(int_vec),
    .pending(pending), .in_service(in_service), .cnt_exc(cnt_exc)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    if (exp_cnt < 2047) exp_cnt++;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; src_in = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; eret = 1'b0;
    tick(2);
    reset = 1'b1;
    tick();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", int_req); end
    total++; if (int_vec !== 32'h800) begin bad++; $display("FAIL reset_vec got=%h want=00000800", int_vec); end
    total++; if (cnt_exc !== 11'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt_exc); end
    total++; if (pending !== 3'b000 || in_service !== 3'b000) begin bad++;
      $display("FAIL reset_state got pend=%b svc=%b want 000/000", pending, in_service); end
  endtask

  task automatic test_edge_latch();
    src_in[1] = 1'b1;
    tick(2);
    total++; if (pending !== 3'b000) begin bad++; $display("FAIL latch_early got=%b want=000", pending); end
    tick();
    total++; if (pending !== 3'b010) begin bad++; $display("FAIL latch_3rd got=%b want=010", pending); end
    total++; if (int_req !== 1'b1 || int_id !== 2'd1 || int_vec !== 32'h820) begin bad++;
      $display("FAIL latch_req got req=%0b id=%0d vec=%h want 1/1/00000820", int_req, int_id, int_vec); end
    do_ack();
    total++; if (pending !== 3'b000 || in_service !== 3'b010 || cnt_exc !== 11'd1) begin bad++;
      $display("FAIL latch_ack got pend=%b svc=%b cnt=%0d want 000/010/1", pending, in_service, cnt_exc); end
    tick(6);
    total++; if (int_req !== 1'b0 || pending !== 3'b000) begin bad++;
      $display("FAIL latch_level got req=%0b pend=%b want 0/000", int_req, pending); end
    do_eret();
    src_in = '0;
    tick(3);
    total++; if (in_service !== 3'b000 || int_req !== 1'b0) begin bad++;
      $display("FAIL latch_eret got svc=%b req=%0b want 000/0", in_service, int_req); end
  endtask

  task automatic test_preempt();
    src_in[2] = 1'b1;
    tick(3);
    do_ack();
    src_in[0] = 1'b1;
    tick(3);
    total++; if (int_req !== 1'b1 || int_id !== 2'd0 || int_vec !== 32'h800) begin bad++;
      $display("FAIL preempt_req got req=%0b id=%0d vec=%h want 1/0/00000800", int_req, int_id, int_vec); end
    do_ack();
    total++; if (in_service !== 3'b101) begin bad++; $display("FAIL preempt_nest got=%b want=101", in_service); end
    do_eret();
    total++; if (in_service !== 3'b100) begin bad++; $display("FAIL preempt_eret1 got=%b want=100", in_service); end
    do_eret();
    total++; if (in_service !== 3'b000) begin bad++; $display("FAIL preempt_eret2 got=%b want=000", in_service); end
    src_in = '0;
    tick(3);
  endtask

  task automatic test_no_preempt();
    src_in[0] = 1'b1;
    tick(3);
    do_ack();
    src_in[1] = 1'b1;
    tick(3);
    total++; if (pending !== 3'b010 || int_req !== 1'b0) begin bad++;
      $display("FAIL lowpri_wait got pend=%b req=%0b want 010/0", pending, int_req); end
    do_eret();
    total++; if (int_req !== 1'b1 || int_id !== 2'd1) begin bad++;
      $display("FAIL lowpri_after got req=%0b id=%0d want 1/1", int_req, int_id); end
    do_ack();
    do_eret();
    src_in = '0;
    tick(3);
    total++; if (cnt_exc !== 11'(exp_cnt)) begin bad++; $display("FAIL count_mid got=%0d want=%0d", cnt_exc, exp_cnt); end
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 3'b011;
    tick();
    mask_we = 1'b0;
    src_in[2] = 1'b1;
    tick(3);
    total++; if (pending !== 3'b100 || int_req !== 1'b0) begin bad++;
      $display("FAIL mask_hold got pend=%b req=%0b want 100/0", pending, int_req); end
    mask_we = 1'b1; mask_wdata = 3'b111;
    #2;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL mask_before_edge got=%0b want=0", int_req); end
    tick();
    mask_we = 1'b0;
    total++; if (int_req !== 1'b1 || int_id !== 2'd2 || int_vec !== 32'h840) begin bad++;
      $display("FAIL mask_unmask got req=%0b id=%0d vec=%h want 1/2/00000840", int_req, int_id, int_vec); end
    do_ack();
    do_eret();
    src_in = '0;
    tick(3);
  endtask

  task automatic test_corner_cases();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    total++; if (in_service !== 3'b000 || pending !== 3'b000 || cnt_exc !== 11'(exp_cnt)) begin bad++;
      $display("FAIL ack_idle got svc=%b pend=%b cnt=%0d want 000/000/%0d", in_service, pending, cnt_exc, exp_cnt); end
    do_eret();
    total++; if (in_service !== 3'b000) begin bad++; $display("FAIL eret_idle got=%b want=000", in_service); end

    // New edge on src 2 lands on the same edge as its ack: the set must win.
    src_in[2] = 1'b1;
    tick(3);
    src_in[2] = 1'b0;
    tick(3);
    src_in[2] = 1'b1;
    tick(2);
    do_ack();
    total++; if (pending !== 3'b100 || in_service !== 3'b100 || int_req !== 1'b0) begin bad++;
      $display("FAIL set_wins got pend=%b svc=%b req=%0b want 100/100/0", pending, in_service, int_req); end
    do_eret();
    total++; if (int_req !== 1'b1 || int_id !== 2'd2) begin bad++;
      $display("FAIL set_wins_rereq got req=%0b id=%0d want 1/2", int_req, int_id); end
    do_ack();
    do_eret();
    src_in = '0;
    tick(3);

    src_in[1] = 1'b1;
    tick(3);
    do_ack();
    src_in[0] = 1'b1;
    tick(3);
    eret = 1'b1;
    do_ack();
    eret = 1'b0;
    total++; if (in_service !== 3'b001 || pending !== 3'b000) begin bad++;
      $display("FAIL ack_eret got svc=%b pend=%b want 001/000", in_service, pending); end
    do_eret();
    src_in = '0;
    tick(3);
    total++; if (cnt_exc !== 11'(exp_cnt)) begin bad++; $display("FAIL count_pre_sat got=%0d want=%0d", cnt_exc, exp_cnt); end
  endtask

  task automatic test_saturation();
    bit timed_out = 1'b0;
    for (int n = 0; n < 2045 && !timed_out; n++) begin
      int w;
      src_in[0] = 1'b1;
      w = 0;
      while (int_req !== 1'b1 && w < 10) begin
        tick();
        w++;
      end
      if (int_req !== 1'b1) begin
        timed_out = 1'b1;
        total++; bad++;
        $display("FAIL sat_timeout iter=%0d req=%0b want=1", n, int_req);
      end else begin
        do_ack();
        do_eret();
        src_in = '0;
        tick(2);
      end
    end
    tick(2);
    total++; if (cnt_exc !== 11'd2047) begin bad++; $display("FAIL sat_hold got=%0d want=2047", cnt_exc); end
  endtask

  task automatic test_reset_mid_handler();
    src_in[0] = 1'b1;
    tick(3);
    do_ack();
    src_in[1] = 1'b1;
    tick(3);
    reset = 1'b0;
    #2;
    total++; if (pending !== 3'b000 || in_service !== 3'b000 || cnt_exc !== 11'd0) begin bad++;
      $display("FAIL mid_reset got pend=%b svc=%b cnt=%0d want 000/000/0", pending, in_service, cnt_exc); end
    total++; if (int_req !== 1'b0 || int_vec !== 32'h800) begin bad++;
      $display("FAIL mid_reset_req got req=%0b vec=%h want 0/00000800", int_req, int_vec); end
    src_in = '0;
    tick(2);
    reset = 1'b1;
    tick(5);
    total++; if (int_req !== 1'b0 || pending !== 3'b000) begin bad++;
      $display("FAIL post_reset got req=%0b pend=%b want 0/000", int_req, pending); end
    src_in[2] = 1'b1;
    tick(3);
    total++; if (int_req !== 1'b1 || int_id !== 2'd2) begin bad++;
      $display("FAIL post_reset_edge got req=%0b id=%0d want 1/2", int_req, int_id); end
  endtask

  initial begin
    test_reset();
    test_edge_latch();
    test_preempt();
    test_no_preempt();
    test_mask();
    test_corner_cases();
    test_saturation();
    test_reset_mid_handler();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
